// File: rtl/imem_arbiter.sv
// +--------------------------------------------------------------------------+
// | imem_arbiter : serialises IF fetches and loader accesses onto one IMEM   |
// |                port, absorbing read latency and squashing flushed fetches |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              fetch_req_i,
  input  logic [31:0]       fetch_addr_i,
  input  logic              fetch_flush_i,
  output logic              fetch_gnt_o,
  output logic              fetch_valid_o,
  output logic [31:0]       fetch_data_o,
  input  logic              load_req_i,
  input  logic              load_we_i,
  input  logic [31:0]       load_addr_i,
  input  logic [31:0]       load_wdata_i,
  output logic              load_gnt_o,
  output logic              load_valid_o,
  output logic [31:0]       load_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int LAT_W    = 3;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                owner_load_q, owner_load_d;
  logic                owner_we_q, owner_we_d;
  logic                squash_q, squash_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [31:0]         fetch_data_q, fetch_data_d;
  logic                load_valid_q, load_valid_d;
  logic [31:0]         load_rdata_q, load_rdata_d;

  logic                grant_ok;
  logic                load_win;
  logic                fetch_gnt;
  logic                load_gnt;
  logic                capture;
  logic                fetch_busy;
  logic                squash_now;
  logic                unused_addr_bits;

  // Byte addresses reduce to word indices; the dropped bits are intentional.
  assign unused_addr_bits = ^{fetch_addr_i[31:ADDR_W+2], fetch_addr_i[1:0],
                              load_addr_i[31:ADDR_W+2], load_addr_i[1:0]};

  always_comb begin
    grant_ok   = reset_n_i && (state_q == S_IDLE);
    load_win   = load_req_i && (!fetch_req_i || (starve_q == STARVE_LIM));
    fetch_gnt  = grant_ok && fetch_req_i && !load_win;
    load_gnt   = grant_ok && load_win;
    capture    = (state_q == S_WAIT) && (lat_q == '0);
    fetch_busy = (state_q != S_IDLE) && !owner_load_q;
    // A flush arriving in the capture cycle itself must still kill the response.
    squash_now = squash_q || (fetch_busy && fetch_flush_i);
  end

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    owner_load_d = owner_load_q;
    owner_we_d   = owner_we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_gnt || load_gnt) begin
          state_d      = S_ISSUE;
          owner_load_d = load_gnt;
          owner_we_d   = load_gnt && load_we_i;
          mem_en_d     = 1'b1;
          mem_we_d     = load_gnt && load_we_i;
          mem_addr_d   = load_gnt ? load_addr_i[ADDR_W+1:2] : fetch_addr_i[ADDR_W+1:2];
          mem_wdata_d  = load_gnt ? load_wdata_i : 32'h0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        lat_d   = LAT_LOAD;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    squash_d = 1'b0;
    if ((state_q != S_IDLE) && !capture) begin
      squash_d = squash_now;
    end

    fetch_valid_d = capture && !owner_load_q && !squash_now;
    fetch_data_d  = fetch_valid_d ? mem_rdata_i : fetch_data_q;
    load_valid_d  = capture && owner_load_q;
    load_rdata_d  = (load_valid_d && !owner_we_q) ? mem_rdata_i : load_rdata_q;

    starve_d = starve_q;
    if (!load_req_i || load_gnt) begin
      starve_d = '0;
    end else if (fetch_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      lat_q         <= '0;
      starve_q      <= '0;
      owner_load_q  <= 1'b0;
      owner_we_q    <= 1'b0;
      squash_q      <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      load_valid_q  <= 1'b0;
      load_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      starve_q      <= starve_d;
      owner_load_q  <= owner_load_d;
      owner_we_q    <= owner_we_d;
      squash_q      <= squash_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      load_valid_q  <= load_valid_d;
      load_rdata_q  <= load_rdata_d;
    end
  end

  assign fetch_gnt_o   = fetch_gnt;
  assign load_gnt_o    = load_gnt;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_data_o  = fetch_data_q;
  assign load_valid_o  = load_valid_q;
  assign load_rdata_o  = load_rdata_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port instruction memory between the IF-stage fetch path and a program-load/debug port. It serialises accesses so only one is outstanding at a time, and it absorbs a configurable memory read latency. A fetch flush squashes the in-flight fetch response on a PC redirect. It sits between the IF stage and the IMEM array and replaces direct combinational IMEM indexing by PC.

## Interface
- ADDR_W, 8, IMEM word-address width (256 words)
- LATENCY, 2, memory read latency in cycles after the mem_en cycle (legal 1..4)
- STARVE_MAX, 4, consecutive fetch grants allowed while load_req is pending before the loader is forced

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request, level
- fetch_addr  in  32  byte PC; word index = fetch_addr[ADDR_W+1:2]
- fetch_flush  in  1  squash in-flight fetch response
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_valid  out  1  one-cycle pulse, fetch_data valid
- fetch_data  out  32  fetched instruction
- load_req  in  1  loader request, level
- load_we  in  1  1 = write, 0 = read
- load_addr  in  32  byte address; word index as for fetch
- load_wdata  in  32  write data
- load_gnt  out  1  loader accepted this cycle (combinational)
- load_valid  out  1  one-cycle pulse; read data valid, or write complete
- load_rdata  out  32  read data
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  word address, registered
- mem_wdata  out  32  write data, registered
- mem_rdata  in  32  memory read data, valid LATENCY cycles after the mem_en cycle

## Operation
- FSM states:
  - IDLE: grant allowed.
  - ISSUE: mem_en high for exactly one cycle.
  - WAIT: count LATENCY cycles, then capture.
- Transitions:
  - IDLE → ISSUE on any grant.
  - ISSUE → WAIT always.
  - WAIT → IDLE when the count expires; response registered on that edge.
- Arbitration, evaluated only in IDLE:
  - Fetch has priority.
  - The loader wins if fetch_req=0, or if load_req=1 and starve_cnt==STARVE_MAX.
  - At most one of fetch_gnt/load_gnt is high, and only in IDLE.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - +1 on each fetch grant while load_req=1.
  - Cleared on a load grant, or in any cycle with load_req=0.
  - Saturates at STARVE_MAX.
- On grant, register the owner, word address, we (fetch always 0) and wdata. These drive mem_* during ISSUE.
- Response handling:
  - Owner fetch: fetch_data ← mem_rdata and fetch_valid pulses, unless the squash flag is set.
  - Owner load: load_valid pulses. On reads, load_rdata ← mem_rdata; on writes, load_rdata holds its previous value.
- Flush:
  - fetch_flush=1 in any cycle while a fetch is in ISSUE/WAIT, including the capture cycle, sets the squash flag.
  - A squashed response produces no fetch_valid, and fetch_data is not updated.
  - The flag clears on return to IDLE.
  - fetch_flush has no effect on loader transactions or in IDLE.
- Address handling:
  - Address bits [1:0] are ignored; misaligned addresses access the containing word.
  - Bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^ADDR_W words.

## Timing
- Reset (reset_n=0, asynchronous):
  - All outputs go to 0: gnt, valid, data, mem_* all zero.
  - FSM goes to IDLE; starve_cnt and squash flag go to 0.
- Reset mid-transaction drops the transaction: no valid after release. First grant is possible in the first cycle after deassertion.
- Grant at cycle t:
  - mem_en=1 at t+1.
  - mem_rdata sampled at end of t+1+LATENCY.
  - valid=1 at t+2+LATENCY.
- FSM is IDLE in the valid cycle, so a new grant can coincide with valid. Back-to-back throughput is one access per LATENCY+2 cycles.
- Requesters hold req/addr/we/wdata until they see their gnt; inputs are sampled only in the gnt cycle.
- If req is dropped before gnt, nothing is issued.
- Simultaneous fetch_req and load_req in IDLE: fetch wins unless starve_cnt==STARVE_MAX.

## Test plan
- Reset and basic fetch:
  - Stimulus: reset_n low, then high; fetch_req=1, fetch_addr=0x4; mem returns 0x00432020.
  - Required: all outputs 0 during reset; gnt at t, mem_addr=1 at t+1, fetch_valid with 0x00432020 at t+4 (LATENCY=2).
- Loader write then read:
  - Stimulus: load_we=1, addr 0x8, wdata 0xAC250008; then a read of 0x8.
  - Required: mem_we=1, mem_addr=2, mem_wdata=0xAC250008; load_valid pulses for both; read returns 0xAC250008.
- Starvation:
  - Stimulus: fetch_req and load_req held high.
  - Required: exactly 4 fetch grants, then one load grant, then the cycle repeats.
- Flush:
  - Stimulus: fetch at 0x10, fetch_flush pulsed during WAIT; then again in the capture cycle.
  - Required: no fetch_valid in either case; the next fetch completes normally.
- Reset mid-transaction and wrap:
  - Stimulus: reset_n low during WAIT; then fetch_addr=0x404.
  - Required: no valid after release; the 0x404 fetch drives mem_addr=1 (wrap).
